// File: rtl/chirp_phase_inc_gen_if.sv
// rtl/chirp_phase_inc_gen_if.sv - settings bus and phase-increment stream for chirp_phase_inc_gen
interface chirp_phase_inc_gen_if;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (
    output set_stb, set_addr, set_data, tready,
    input  tdata, tlast, tvalid
  );

  modport slave (
    input  set_stb, set_addr, set_data, tready,
    output tdata, tlast, tvalid
  );
endinterface

// File: rtl/chirp_phase_inc_gen.sv
// rtl/chirp_phase_inc_gen.sv - stepped linear sweep of phase increments on an output stream
// Optional CHIRP_GEN_FINAL_CLAMP_EN: an overshooting sweep emits stop as its final value.
module chirp_phase_inc_gen (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        enable_i,
  chirp_phase_inc_gen_if.slave        bus
);
  localparam logic [7:0] SR_START_ADDR = 8'd131;
  localparam logic [7:0] SR_STOP_ADDR  = 8'd132;
  localparam logic [7:0] SR_STEP_ADDR  = 8'd133;
  localparam logic [7:0] SR_DWELL_ADDR = 8'd134;
  localparam logic [7:0] SR_CTRL_ADDR  = 8'd135;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] start_q, start_d, stop_q, stop_d, cur_q, cur_d;
  logic [15:0]        step_q, step_d, dwell_q, dwell_d, cnt_q, cnt_d;
  logic               cont_q, cont_d, tlast_q, tlast_d;
  logic               go, beat;
  logic               unused_set_data;

  assign unused_set_data = ^bus.set_data[31:16];

  function automatic logic [15:0] dwell_max(input logic [15:0] dwell);
    return (dwell == 16'd0) ? 16'd0 : dwell - 16'd1;
  endfunction

  // Widened arithmetic so stepping past +/-32768 compares correctly against stop.
  function automatic logic signed [17:0] raw_next(input logic signed [15:0] cur,
                                                  input logic signed [15:0] start,
                                                  input logic signed [15:0] stop,
                                                  input logic [15:0]        step);
    logic signed [17:0] c, s;
    c = $signed({{2{cur[15]}}, cur});
    s = $signed({2'b00, step});
    return (stop >= start) ? c + s : c - s;
  endfunction

  function automatic logic overshoot(input logic signed [15:0] cur,
                                     input logic signed [15:0] start,
                                     input logic signed [15:0] stop,
                                     input logic [15:0]        step);
    logic signed [17:0] nx, se;
    nx = raw_next(cur, start, stop, step);
    se = $signed({{2{stop[15]}}, stop});
    return (stop >= start) ? (nx > se) : (nx < se);
  endfunction

  function automatic logic is_last(input logic signed [15:0] cur,
                                   input logic signed [15:0] start,
                                   input logic signed [15:0] stop,
                                   input logic [15:0]        step);
`ifdef CHIRP_GEN_FINAL_CLAMP_EN
    return (cur == stop) || (step == 16'd0);
`else
    return (cur == stop) || (step == 16'd0) || overshoot(cur, start, stop, step);
`endif
  endfunction

  function automatic logic signed [15:0] next_val(input logic signed [15:0] cur,
                                                  input logic signed [15:0] start,
                                                  input logic signed [15:0] stop,
                                                  input logic [15:0]        step);
    logic signed [17:0] nx;
    nx = raw_next(cur, start, stop, step);
`ifdef CHIRP_GEN_FINAL_CLAMP_EN
    return overshoot(cur, start, stop, step) ? stop : nx[15:0];
`else
    return nx[15:0];
`endif
  endfunction

  always_comb begin
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    go      = 1'b0;
    if (bus.set_stb) begin
      case (bus.set_addr)
        SR_START_ADDR: start_d = bus.set_data[15:0];
        SR_STOP_ADDR:  stop_d  = bus.set_data[15:0];
        SR_STEP_ADDR:  step_d  = bus.set_data[15:0];
        SR_DWELL_ADDR: dwell_d = bus.set_data[15:0];
        SR_CTRL_ADDR: begin
          cont_d = bus.set_data[1];
          go     = bus.set_data[0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    beat    = (state_q == RUN) && enable_i && bus.tready;
    if (beat) begin
      if (cnt_q < dwell_max(dwell_q)) begin
        cnt_d = cnt_q + 16'd1;
      end else if (!is_last(cur_q, start_q, stop_q, step_q)) begin
        cur_d = next_val(cur_q, start_q, stop_q, step_q);
        cnt_d = 16'd0;
      end else if (cont_q) begin
        cur_d = start_q;
        cnt_d = 16'd0;
      end else begin
        state_d = IDLE;
      end
    end
    if (go) begin
      state_d = RUN;
      cur_d   = start_q;
      cnt_d   = 16'd0;
    end
    if (clear_i) begin
      state_d = IDLE;
    end
    // tlast is registered from the values the next cycle will present.
    tlast_d = (state_d == RUN) && is_last(cur_d, start_d, stop_d, step_d)
              && (cnt_d == dwell_max(dwell_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      tlast_q <= tlast_d;
    end
  end

  assign bus.tdata  = cur_q;
  assign bus.tlast  = tlast_q;
  assign bus.tvalid = (state_q == RUN) && enable_i;
endmodule

// File: tb/tb_chirp_phase_inc_gen.sv
// tb/tb_chirp_phase_inc_gen.sv - directed vector bench for chirp_phase_inc_gen
module tb_chirp_phase_inc_gen;
  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic enable;
  int   n_vec = 0;
  int   n_err = 0;

  chirp_phase_inc_gen_if bus ();

  chirp_phase_inc_gen dut (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .enable_i (enable),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start;
    logic [15:0] stop;
    logic [15:0] step;
    logic [15:0] dwell;
    int          nvals;
    logic [15:0] v [0:4];
  } sweep_t;

  sweep_t tbl [0:6];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_row(input int i, input int s, input int e, input int st, input int d,
                         input int n, input int v0, input int v1, input int v2,
                         input int v3, input int v4);
    tbl[i].start = 16'(s);
    tbl[i].stop  = 16'(e);
    tbl[i].step  = 16'(st);
    tbl[i].dwell = 16'(d);
    tbl[i].nvals = n;
    tbl[i].v[0]  = 16'(v0);
    tbl[i].v[1]  = 16'(v1);
    tbl[i].v[2]  = 16'(v2);
    tbl[i].v[3]  = 16'(v3);
    tbl[i].v[4]  = 16'(v4);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.set_stb  = 1'b1;
    bus.set_addr = addr;
    bus.set_data = data;
    @(negedge clk);
    bus.set_stb  = 1'b0;
  endtask

  task automatic program_row(input int i);
    wr(8'd131, {16'd0, tbl[i].start});
    wr(8'd132, {16'd0, tbl[i].stop});
    wr(8'd133, {16'd0, tbl[i].step});
    wr(8'd134, {16'd0, tbl[i].dwell});
  endtask

  task automatic run_sweep(input int i);
    int dw, total;
    dw    = (tbl[i].dwell == 16'd0) ? 1 : int'(tbl[i].dwell);
    total = tbl[i].nvals * dw;
    program_row(i);
    wr(8'd135, 32'd1);
    for (int b = 0; b < total; b++) begin
      chk($sformatf("sweep%0d_valid_b%0d", i, b), 16'(bus.tvalid), 16'd1);
      chk($sformatf("sweep%0d_tdata_b%0d", i, b), bus.tdata, tbl[i].v[b / dw]);
      chk($sformatf("sweep%0d_tlast_b%0d", i, b), 16'(bus.tlast), 16'(b == total - 1));
      @(negedge clk);
    end
    chk($sformatf("sweep%0d_idle_after", i), 16'(bus.tvalid), 16'd0);
  endtask

  initial begin
    logic [15:0] cexp [0:4];
    logic        clast [0:4];
    logic [15:0] prev_td;
    logic        prev_tl, prev_acc, have_prev, acc;
    int          k, cyc;

    set_row(0, 100, 400, 100, 1, 4, 100, 200, 300, 400, 0);
    set_row(1, 100, 400, 100, 3, 4, 100, 200, 300, 400, 0);
    set_row(2, 100, 400, 100, 0, 4, 100, 200, 300, 400, 0);
    set_row(3, 400, 100, 150, 1, 3, 400, 250, 100, 0, 0);
`ifdef CHIRP_GEN_FINAL_CLAMP_EN
    set_row(4, 0, 250, 100, 1, 4, 0, 100, 200, 250, 0);
`else
    set_row(4, 0, 250, 100, 1, 3, 0, 100, 200, 0, 0);
`endif
    set_row(5, 5, 9, 0, 2, 1, 5, 0, 0, 0, 0);
    set_row(6, 7, 7, 3, 1, 1, 7, 0, 0, 0, 0);

    rst          = 1'b1;
    clear        = 1'b0;
    enable       = 1'b1;
    bus.tready   = 1'b1;
    bus.set_stb  = 1'b0;
    bus.set_addr = '0;
    bus.set_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_tdata", bus.tdata, 16'd0);
    chk("reset_tlast", 16'(bus.tlast), 16'd0);
    chk("reset_tvalid", 16'(bus.tvalid), 16'd0);
    rst = 1'b0;

    for (int i = 0; i <= 6; i++) run_sweep(i);

    // Continuous wrap across the full signed range.
    wr(8'd131, 32'h0000_8000);
    wr(8'd132, 32'h0000_7FFF);
    wr(8'd133, 32'h0000_7FFF);
    wr(8'd134, 32'd1);
`ifdef CHIRP_GEN_FINAL_CLAMP_EN
    cexp[0] = 16'h8000; cexp[1] = 16'hFFFF; cexp[2] = 16'h7FFE; cexp[3] = 16'h7FFF; cexp[4] = 16'h8000;
    clast[0] = 1'b0; clast[1] = 1'b0; clast[2] = 1'b0; clast[3] = 1'b1; clast[4] = 1'b0;
`else
    cexp[0] = 16'h8000; cexp[1] = 16'hFFFF; cexp[2] = 16'h7FFE; cexp[3] = 16'h8000; cexp[4] = 16'hFFFF;
    clast[0] = 1'b0; clast[1] = 1'b0; clast[2] = 1'b1; clast[3] = 1'b0; clast[4] = 1'b0;
`endif
    wr(8'd135, 32'd3);
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("cont_valid_b%0d", b), 16'(bus.tvalid), 16'd1);
      chk($sformatf("cont_tdata_b%0d", b), bus.tdata, cexp[b]);
      chk($sformatf("cont_tlast_b%0d", b), 16'(bus.tlast), 16'(clast[b]));
      @(negedge clk);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_valid", 16'(bus.tvalid), 16'd0);
    wr(8'd135, 32'd1);
    chk("replay_valid", 16'(bus.tvalid), 16'd1);
    chk("replay_tdata", bus.tdata, 16'h8000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // Random ready/enable on the dwell=3 sweep.
    program_row(1);
    wr(8'd135, 32'd1);
    k = 0; cyc = 0; have_prev = 1'b0; prev_acc = 1'b0; prev_td = '0; prev_tl = 1'b0;
    while (k < 12 && cyc < 300) begin
      bus.tready = ($urandom_range(0, 3) != 0);
      enable     = ($urandom_range(0, 4) != 0);
      #1;
      if (!enable) chk("gate_valid", 16'(bus.tvalid), 16'd0);
      if (have_prev && !prev_acc) begin
        chk("stall_tdata", bus.tdata, prev_td);
        chk("stall_tlast", 16'(bus.tlast), 16'(prev_tl));
      end
      acc = bus.tvalid && bus.tready;
      if (acc) begin
        chk($sformatf("rnd_tdata_k%0d", k), bus.tdata, tbl[1].v[k / 3]);
        chk($sformatf("rnd_tlast_k%0d", k), 16'(bus.tlast), 16'(k == 11));
        k++;
      end
      prev_td = bus.tdata; prev_tl = bus.tlast; prev_acc = acc; have_prev = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk("rnd_beats_done", 16'(k), 16'd12);
    bus.tready = 1'b1;
    enable     = 1'b1;
    #1;
    chk("rnd_idle_after", 16'(bus.tvalid), 16'd0);

    // Asynchronous reset in mid-sweep.
    program_row(0);
    wr(8'd135, 32'd1);
    chk("ar_tdata0", bus.tdata, 16'd100);
    @(negedge clk);
    chk("ar_tdata1", bus.tdata, 16'd200);
    #2 rst = 1'b1;
    #1;
    chk("ar_tdata", bus.tdata, 16'd0);
    chk("ar_tvalid", 16'(bus.tvalid), 16'd0);
    chk("ar_tlast", 16'(bus.tlast), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    wr(8'd135, 32'd1);
    chk("post_reset_valid", 16'(bus.tvalid), 16'd1);
    chk("post_reset_tdata", bus.tdata, 16'd0);
    chk("post_reset_tlast", 16'(bus.tlast), 16'd1);
    @(negedge clk);
    chk("post_reset_idle", 16'(bus.tvalid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
